// File: rtl/bcd_add_sequencer.sv
// ---------------------------------------------------------------------------
// bcd_add_sequencer
//
// Purpose:
//   Adds two 4-digit BCD operands one digit per clock, digit 0 first. A
//   single 4-bit binary adder and one decimal-correction stage are shared by
//   all four digits. The operation is CHECK (1 cycle), ADD (4 cycles, one per
//   digit), then DONE (1 cycle), so done rises in the cycle after the fifth
//   clock edge following the start edge.
//
// Optional feature (compile-time macro):
//   BCD_ERR_CHECK_EN - when defined, CHECK scans all eight operand digits.
//   If any digit is above 9, error is set, sum and c_out stay 0, and the FSM
//   goes straight to DONE. When undefined, error is tied to 0 and invalid
//   digits are added with no flag.
//
// Ports:
//   clk        in   1   clock, all state changes on its rising edge
//   reset      in   1   asynchronous, active-high reset
//   start      in   1   begin one addition (sampled only in IDLE)
//   a, b       in   16  BCD operands, digit 0 in bits [3:0]
//   c_in       in   1   carry into digit 0
//   busy       out  1   high in every state other than IDLE
//   done       out  1   one-cycle pulse, result valid
//   sum        out  16  BCD result, held until the next accepted start
//   c_out      out  1   decimal carry out of digit 3
//   error      out  1   invalid-operand flag
//   state_dbg  out  2   current FSM state (0 IDLE, 1 CHECK, 2 ADD, 3 DONE)
//
// Handshake: start is a request with no ready. It is accepted on any rising
// edge where the block is in IDLE (busy=0) and start=1. It is ignored while
// busy=1. done pulses for exactly one cycle per accepted start unless reset
// intervenes, and the results stay stable until the next accepted start.
// ---------------------------------------------------------------------------
module bcd_add_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        c_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] sum,
    output logic        c_out,
    output logic        error,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_ADD   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [15:0] a_q;
    logic [15:0] b_q;
    logic        carry_q;
    logic [1:0]  idx_q;
    logic [15:0] sum_q;
    logic        c_out_q;

    // Shared digit datapath.
    logic [3:0]  a_d;
    logic [3:0]  b_d;
    logic [4:0]  t;
    logic [3:0]  digit_fix;
    logic        carry_nxt;
    logic        operand_bad;

    // -----------------------------------------------------------------------
    // Digit adder and decimal correction. Adding 6 modulo 16 to a result
    // above 9 skips the six unused 4-bit codes; only the low nibble is kept.
    // -----------------------------------------------------------------------
    always_comb begin
        a_d       = a_q[{idx_q, 2'b00} +: 4];
        b_d       = b_q[{idx_q, 2'b00} +: 4];
        t         = {1'b0, a_d} + {1'b0, b_d} + {4'b0000, carry_q};
        carry_nxt = (t > 5'd9);
        if (carry_nxt) begin
            digit_fix = t[3:0] + 4'd6;
        end else begin
            digit_fix = t[3:0];
        end
    end

`ifdef BCD_ERR_CHECK_EN
    logic err_q;

    // Any of the eight registered operand digits above 9.
    always_comb begin
        operand_bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (a_q[i*4 +: 4] > 4'd9) operand_bad = 1'b1;
            if (b_q[i*4 +: 4] > 4'd9) operand_bad = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (state == S_IDLE && start) begin
            err_q <= 1'b0;
        end else if (state == S_CHECK && operand_bad) begin
            err_q <= 1'b1;
        end
    end

    assign error = err_q;
`else
    assign operand_bad = 1'b0;
    assign error       = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_CHECK;
            S_CHECK: state_nxt = operand_bad ? S_DONE : S_ADD;
            S_ADD:   if (idx_q == 2'd3) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    always_comb begin
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
        sum       = sum_q;
        c_out     = c_out_q;
        state_dbg = state;
    end

    // -----------------------------------------------------------------------
    // Datapath registers. Operands are captured only on an accepted start,
    // so a start seen while busy cannot disturb the running addition. Only
    // the digit at the current index is written in each ADD cycle.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q     <= 16'h0000;
            b_q     <= 16'h0000;
            carry_q <= 1'b0;
            idx_q   <= 2'd0;
            sum_q   <= 16'h0000;
            c_out_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= c_in;
                        idx_q   <= 2'd0;
                        sum_q   <= 16'h0000;
                        c_out_q <= 1'b0;
                    end
                end
                S_ADD: begin
                    sum_q[{idx_q, 2'b00} +: 4] <= digit_fix;
                    carry_q                    <= carry_nxt;
                    idx_q                      <= idx_q + 2'd1;
                    if (idx_q == 2'd3) c_out_q <= carry_nxt;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_add_sequencer.sv
// ---------------------------------------------------------------------------
// Testbench for bcd_add_sequencer. Expected results ({error, c_out, sum})
// are pushed to exp_q when an operation is launched and popped when done
// is observed.
// ---------------------------------------------------------------------------
module tb_bcd_add_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        c_in;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        c_out;
    logic        error;
    logic [1:0]  state_dbg;

    logic [17:0] exp_q[$];
    int          checks;
    int          errors;

    bcd_add_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .c_out     (c_out),
        .error     (error),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required finish before 500000");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [17:0] bcd_model(input logic [15:0] ma, input logic [15:0] mb,
                                              input logic mc);
        logic [15:0] s;
        logic        c;
        logic [4:0]  t;
        s = 16'h0000;
        c = mc;
`ifdef BCD_ERR_CHECK_EN
        for (int i = 0; i < 4; i++) begin
            if (ma[i*4 +: 4] > 4'd9 || mb[i*4 +: 4] > 4'd9) return {1'b1, 1'b0, 16'h0000};
        end
`endif
        for (int i = 0; i < 4; i++) begin
            t = {1'b0, ma[i*4 +: 4]} + {1'b0, mb[i*4 +: 4]} + {4'b0000, c};
            if (t > 5'd9) begin
                s[i*4 +: 4] = t[3:0] + 4'd6;
                c = 1'b1;
            end else begin
                s[i*4 +: 4] = t[3:0];
                c = 1'b0;
            end
        end
        return {1'b0, c, s};
    endfunction

    function automatic logic [15:0] rand_bcd();
        logic [15:0] v;
        for (int i = 0; i < 4; i++) v[i*4 +: 4] = 4'($urandom_range(0, 9));
        return v;
    endfunction

    // ---------------- driver: launch, wait for done, compare ----------------
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tc,
                          input logic [17:0] exp, input int exp_lat, input string name);
        int          cycles;
        logic        seen;
        logic [17:0] e;
        logic [17:0] got;
        @(negedge clk);
        a = ta; b = tb_; c_in = tc; start = 1'b1;
        exp_q.push_back(exp);
        @(posedge clk);
        #1 start = 1'b0;
        cycles = 0;
        seen   = 1'b0;
        while (!seen && cycles < 20) begin
            @(negedge clk);
            cycles++;
            if (done) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_timeout: done not seen in %0d cycles, required within %0d", name, cycles, exp_lat);
            void'(exp_q.pop_front());
            return;
        end
        checks++;
        if (cycles !== exp_lat) begin
            errors++;
            $display("FAIL %s_latency: got %0d cycles, required %0d", name, cycles, exp_lat);
        end
        e   = exp_q.pop_front();
        got = {error, c_out, sum};
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL %s_result: got err=%b cout=%b sum=%h, required err=%b cout=%b sum=%h",
                     name, got[17], got[16], got[15:0], e[17], e[16], e[15:0]);
        end
        // done is one cycle only; results hold afterwards in IDLE
        @(negedge clk);
        @(negedge clk);
        got = {error, c_out, sum};
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || got !== e) begin
            errors++;
            $display("FAIL %s_hold: done=%b busy=%b err=%b cout=%b sum=%h, required done=0 busy=0 sum=%h",
                     name, done, busy, got[17], got[16], got[15:0], e[15:0]);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1; start = 1'b0; a = 16'h0; b = 16'h0; c_in = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== 16'h0000 || c_out !== 1'b0 ||
            error !== 1'b0 || state_dbg !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b sum=%h cout=%b err=%b st=%0d, required all 0",
                     busy, done, sum, c_out, error, state_dbg);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        run_op(16'h0005, 16'h0006, 1'b1, {1'b0, 1'b0, 16'h0012}, 6, "add_5_6_c1");
        run_op(16'h9999, 16'h0001, 1'b0, {1'b0, 1'b1, 16'h0000}, 6, "ripple_9999");
        run_op(16'h0009, 16'h0009, 1'b1, {1'b0, 1'b0, 16'h0019}, 6, "add_9_9_c1");
        run_op(16'h0010, 16'h0001, 1'b0, {1'b0, 1'b0, 16'h0011}, 6, "add_10_1");
        run_op(16'h9999, 16'h9999, 1'b1, {1'b0, 1'b1, 16'h9999}, 6, "max_operands");
    endtask

    task automatic test_invalid();
`ifdef BCD_ERR_CHECK_EN
        run_op(16'h000A, 16'h0001, 1'b0, {1'b1, 1'b0, 16'h0000}, 2, "invalid_digit");
        run_op(16'h1234, 16'hF000, 1'b0, {1'b1, 1'b0, 16'h0000}, 2, "invalid_b_top");
`else
        run_op(16'h000A, 16'h0001, 1'b0, {1'b0, 1'b0, 16'h0011}, 6, "invalid_digit");
`endif
        // error must clear on the next accepted start
        run_op(16'h0001, 16'h0002, 1'b0, {1'b0, 1'b0, 16'h0003}, 6, "after_invalid");
    endtask

    // Digits above the current index stay zero while ADD is in progress.
    task automatic test_progress();
        @(negedge clk);
        a = 16'h1234; b = 16'h4321; c_in = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);   // after first ADD edge
        checks++;
        if (sum !== 16'h0005 || busy !== 1'b1) begin
            errors++;
            $display("FAIL progress_digit0: sum=%h busy=%b, required sum=0005 busy=1", sum, busy);
        end
        @(negedge clk);
        checks++;
        if (sum !== 16'h0055) begin
            errors++;
            $display("FAIL progress_digit1: sum=%h, required 0055", sum);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (sum !== 16'h5555 || busy !== 1'b0) begin
            errors++;
            $display("FAIL progress_final: sum=%h busy=%b, required sum=5555 busy=0", sum, busy);
        end
    endtask

    task automatic test_start_ignored();
        int          cycles;
        logic        seen;
        logic [17:0] e;
        @(negedge clk);
        a = 16'h0258; b = 16'h0147; c_in = 1'b0; start = 1'b1;
        exp_q.push_back({1'b0, 1'b0, 16'h0405});
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);   // in ADD
        a = 16'h9999; b = 16'h9999; c_in = 1'b1; start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        cycles = 4;
        seen   = 1'b0;
        while (!seen && cycles < 20) begin
            @(negedge clk);
            cycles++;
            if (done) seen = 1'b1;
        end
        e = exp_q.pop_front();
        checks++;
        if (!seen || cycles !== 6 || {error, c_out, sum} !== e) begin
            errors++;
            $display("FAIL start_ignored: seen=%b cycles=%0d sum=%h cout=%b, required cycles=6 sum=%h cout=%b",
                     seen, cycles, sum, c_out, e[15:0], e[16]);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL start_ignored_idle: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_reset_mid_op();
        int saw_done;
        @(negedge clk);
        a = 16'h4567; b = 16'h1111; c_in = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);   // into ADD idx 0
        @(posedge clk);   // into ADD idx 1 (second ADD cycle)
        #2 reset = 1'b1;
        #0.5;
        checks++;
        if (busy !== 1'b0 || sum !== 16'h0000 || done !== 1'b0 || state_dbg !== 2'd0) begin
            errors++;
            $display("FAIL reset_mid_op: busy=%b sum=%h done=%b st=%0d, required busy=0 sum=0000 done=0 st=0",
                     busy, sum, done, state_dbg);
        end
        #0.5 reset = 1'b0;
        saw_done = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) saw_done++;
        end
        checks++;
        if (saw_done != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_done: done pulses=%0d busy=%b, required 0 pulses busy=0", saw_done, busy);
        end
        run_op(16'h0123, 16'h0877, 1'b0, {1'b0, 1'b0, 16'h1000}, 6, "after_reset");
    endtask

    task automatic test_random();
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rc;
        for (int i = 0; i < 10; i++) begin
            ra = rand_bcd();
            rb = rand_bcd();
            rc = 1'($urandom_range(0, 1));
            run_op(ra, rb, rc, bcd_model(ra, rb, rc), 6, "random");
        end
    endtask

    // ---------------- main sequence and report ----------------
    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_directed();
        test_invalid();
        test_progress();
        test_start_ignored();
        test_reset_mid_op();
        test_random();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_empty: %0d entries left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
